// File: rtl/sl_transmitter_if.sv
// Word handshake between the APB-side producer and the SL transmitter.
// The producer drives data/mode/valid; the transmitter answers with ready.
interface sl_transmitter_if;
    logic [31:0] data;
    logic [1:0]  mode;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output mode,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  mode,
        input  valid,
        output ready
    );
endinterface

// File: rtl/sl_transmitter.sv
// Serialises 8/16/24/32-bit words plus odd parity onto the two-wire SL link.
// Optional feature macro: SL_TX_PARITY_INJECT_EN (adds inj_parity_err_i to flip parity).
module sl_transmitter #(
    parameter int PHASE_CLKS = 4,
    parameter int GAP_CLKS   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sl_transmitter_if.slave       bus,
`ifdef SL_TX_PARITY_INJECT_EN
    input  logic                  inj_parity_err_i,
`endif
    output logic                  sl0_o,
    output logic                  sl1_o,
    output logic                  busy_o
);

    localparam logic [15:0] PH_LAST  = 16'(PHASE_CLKS - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT,
        ST_STOP0,
        ST_STOP,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [5:0]  bit_q, bit_d;
    logic [5:0]  last_q, last_d;
    logic [32:0] frame_q, frame_d;
    logic        sl0_q, sl0_d;
    logic        sl1_q, sl1_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [31:0] masked;
    logic [5:0]  n_bits;
    logic        parity;
    logic [32:0] new_frame;
    logic        accept;

    assign accept = bus.valid && ready_q;

    // Frame image: data bits 0..N-1 followed by the parity bit at position N.
    always_comb begin
        masked = '0;
        n_bits = 6'd8;
        case (bus.mode)
            2'b00: begin
                masked = {24'b0, bus.data[7:0]};
                n_bits = 6'd8;
            end
            2'b01: begin
                masked = {16'b0, bus.data[15:0]};
                n_bits = 6'd16;
            end
            2'b10: begin
                masked = {8'b0, bus.data[23:0]};
                n_bits = 6'd24;
            end
            default: begin
                masked = bus.data;
                n_bits = 6'd32;
            end
        endcase
        parity = ~(^masked);
`ifdef SL_TX_PARITY_INJECT_EN
        if (inj_parity_err_i) begin
            parity = ~parity;
        end
`endif
        new_frame         = {1'b0, masked};
        new_frame[n_bits] = parity;
    end

    // Line outputs are computed from next-state values so they leave flops directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        last_d  = last_q;
        frame_d = frame_q;
        sl0_d   = 1'b1;
        sl1_d   = 1'b1;
        busy_d  = busy_q;
        ready_d = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BIT;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    bit_d   = 6'd0;
                    last_d  = n_bits;
                    frame_d = new_frame;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            ST_BIT: begin
                if (cnt_q == PH_LAST) begin
                    cnt_d   = '0;
                    phase_d = 2'(phase_q + 2'd1);
                    if (phase_q == 2'd3) begin
                        if (bit_q >= last_q) begin
                            state_d = ST_STOP0;
                            sl0_d   = 1'b0;
                        end else begin
                            bit_d = 6'(bit_q + 6'd1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (state_d == ST_BIT && phase_d == 2'd2) begin
                    if (frame_q[bit_d]) begin
                        sl1_d = 1'b0;
                    end else begin
                        sl0_d = 1'b0;
                    end
                end
            end

            ST_STOP0: begin
                state_d = ST_STOP;
                cnt_d   = '0;
                sl0_d   = 1'b0;
                sl1_d   = 1'b0;
            end

            ST_STOP: begin
                if (cnt_q == PH_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    sl0_d = 1'b0;
                    sl1_d = 1'b0;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // Reset aborts any word in flight; lines go straight back to idle-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            bit_q   <= 6'd0;
            last_q  <= 6'd0;
            frame_q <= '0;
            sl0_q   <= 1'b1;
            sl1_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            frame_q <= frame_d;
            sl0_q   <= sl0_d;
            sl1_q   <= sl1_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign sl0_o     = sl0_q;
    assign sl1_o     = sl1_q;
    assign busy_o    = busy_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: stimulus queues expected symbols,
// a line monitor decodes sl0/sl1 pulses and checks them independently.
module tb_sl_transmitter;
    localparam int PH = 4;
    localparam int GP = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sl0_o, sl1_o, busy_o;
`ifdef SL_TX_PARITY_INJECT_EN
    logic inj = 1'b0;
`endif

    sl_transmitter_if bus ();

    sl_transmitter #(.PHASE_CLKS(PH), .GAP_CLKS(GP)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus),
`ifdef SL_TX_PARITY_INJECT_EN
        .inj_parity_err_i (inj),
`endif
        .sl0_o            (sl0_o),
        .sl1_o            (sl1_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_sym_q[$];
    int exp_len_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: symbol 0 = sl0 pulse, 1 = sl1 pulse, 2 = end-of-word marker.
    int cyc = 0, len0 = 0, len1 = 0, frame_start = 0, gap_cnt = 0, sym_idx = 0;
    bit prev_busy = 0, in_gap = 0;
    always @(negedge clk) begin
        int sym, e;
        cyc++;
        if (!reset_n) begin
            len0 = 0; len1 = 0; in_gap = 0; prev_busy = 0; sym_idx = 0; gap_cnt = 0;
        end else begin
            if (busy_o && !prev_busy) frame_start = cyc;
            prev_busy = busy_o;
            if (in_gap) begin
                if (busy_o) gap_cnt++;
                else begin
                    check("gap_len", gap_cnt, GP);
                    check("ready_after_gap", int'(bus.ready), 1);
                    in_gap = 0;
                end
            end
            if (!sl0_o || !sl1_o) begin
                if (!sl0_o) len0++;
                if (!sl1_o) len1++;
            end else if (len0 != 0 || len1 != 0) begin
                if (len0 != 0 && len1 != 0) sym = 2;
                else if (len0 != 0) sym = 0;
                else sym = 1;
                if (exp_sym_q.size() == 0) check("unexpected_symbol", sym, -1);
                else begin
                    e = exp_sym_q.pop_front();
                    check($sformatf("symbol%0d", sym_idx), sym, e);
                end
                if (sym == 2) begin
                    check("stop_sl0_len", len0, PH + 1);
                    check("stop_sl1_len", len1, PH);
                    if (exp_len_q.size() == 0) check("unexpected_frame", cyc - frame_start, -1);
                    else check("frame_len", cyc - frame_start, exp_len_q.pop_front());
                    $display("word done: frame=%0d cycles, %0d data+parity cells", cyc - frame_start, sym_idx);
                    sym_idx = 0;
                    in_gap  = 1;
                    gap_cnt = 1;
                end else begin
                    check($sformatf("pulse_len%0d", sym_idx), (sym == 0) ? len0 : len1, PH);
                    sym_idx++;
                end
                len0 = 0;
                len1 = 0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m, input int p);
        int n, nb;
        @(negedge clk);
        bus.data  = d;
        bus.mode  = m;
        bus.valid = 1'b1;
        n = 0;
        while (!bus.ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(bus.ready), 1);
        nb = 8 * (int'(m) + 1);
        for (int i = 0; i < nb; i++) exp_sym_q.push_back(int'(d[i]));
        exp_sym_q.push_back(p);
        exp_sym_q.push_back(2);
        exp_len_q.push_back((nb + 1) * 4 * PH + 1 + PH);
        @(posedge clk);
        #1 bus.valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_sym_q.size() != 0 || !bus.ready || busy_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", (n < 3000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data  = '0;
        bus.mode  = 2'b00;
        bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset", int'({sl0_o, sl1_o, bus.ready, busy_o}), 4'b1110);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_lines", int'({sl0_o, sl1_o, bus.ready, busy_o}), 4'b1110);
        end

        send(32'h0000_96CA, 2'b01, 1);
        wait_idle();

        send(32'hFFFF_FF00, 2'b00, 1);
        wait_idle();

        send(32'h0000_00B7, 2'b00, 1);
        wait_idle();

        // Inputs changed and valid raised mid-frame must not disturb the word.
        send(32'hFFFF_FFFF, 2'b11, 1);
        repeat (100) @(negedge clk);
        bus.data  = 32'h0;
        bus.mode  = 2'b00;
        bus.valid = 1'b1;
        repeat (20) @(negedge clk);
        check("ready_low_busy", int'({bus.ready, busy_o}), 2'b01);
        bus.valid = 1'b0;
        wait_idle();

        // Abort during bit 5.
        send(32'h0000_96CA, 2'b01, 1);
        repeat (5 * 4 * PH + 6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("abort_lines", int'({sl0_o, sl1_o, bus.ready, busy_o}), 4'b1110);
        exp_sym_q.delete();
        exp_len_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("after_abort", int'({sl0_o, sl1_o, bus.ready, busy_o}), 4'b1110);

        send(32'h00A5_3C01, 2'b10, 0);
        wait_idle();

        send(32'h1234_0001, 2'b00, 0);
        wait_idle();

`ifdef SL_TX_PARITY_INJECT_EN
        inj = 1'b1;
        send(32'h0000_96CA, 2'b01, 0);
        inj = 1'b0;
        wait_idle();
`endif

        check("leftover_symbols", exp_sym_q.size(), 0);
        check("leftover_frames", exp_len_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
